// File: rtl/dcache_nway_wb_if.sv
// Memory-side bus between the data cache and the AXI bridge.
// master = cache side (issues line requests), slave = memory/bridge side.
interface dcache_nway_wb_if #(
  parameter int ADDR_W    = 32,
  parameter int LINE_BITS = 128
) ();
  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_W-1:0]    req_addr;
  logic                 write_en;
  logic [LINE_BITS-1:0] req_Wdata;
  logic                 res_valid;
  logic                 res_ready;
  logic [LINE_BITS-1:0] res_Rdata;

  modport master (
    output req_valid, req_addr, write_en, req_Wdata, res_ready,
    input  req_ready, res_valid, res_Rdata
  );

  modport slave (
    input  req_valid, req_addr, write_en, req_Wdata, res_ready,
    output req_ready, res_valid, res_Rdata
  );
endinterface

// File: rtl/dcache_nway_wb.sv
// N-way set-associative write-back / write-allocate data cache.
// Registered lookup stage, round-robin replacement preferring invalid ways,
// and a full-cache flush that writes back every dirty line.
module dcache_nway_wb #(
  parameter int WAYS      = 4,
  parameter int SETS      = 64,
  parameter int LINE_BITS = 128,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  output logic              flush_busy,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        Conf_dmem,
  input  logic [31:0]       Wdata,
  input  logic              Wena,
  input  logic              Rena,
  output logic [31:0]       Rdata,
  output logic              Rdone,
  output logic              Wdone,
  output logic              stall,
  dcache_nway_wb_if.master  mem
);

  localparam int OFF_W  = $clog2(LINE_BITS / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WORD_W = $clog2(LINE_BITS / 32);
  localparam int LINES  = SETS * WAYS;
  localparam int LI_W   = IDX_W + WAY_W;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOOKUP = 3'd1;
  localparam logic [2:0] WB     = 3'd2;
  localparam logic [2:0] FILL   = 3'd3;
  localparam logic [2:0] WAIT   = 3'd4;
  localparam logic [2:0] FSCAN  = 3'd5;
  localparam logic [2:0] FWB    = 3'd6;

  logic [2:0]           state;
  logic [ADDR_W-1:2]    lk_addr;
  logic [31:0]          lk_wdata;
  logic [3:0]           lk_wmask;
  logic                 lk_we;
  logic [WAY_W-1:0]     victim;
  logic [LI_W-1:0]      fidx;
  logic [LINES-1:0]     valid;
  logic [LINES-1:0]     dirty;
  logic [WAY_W-1:0]     rr [SETS];

  // Line storage is not reset; valid bits alone decide what is live.
  logic [LINE_BITS-1:0] data_mem [LINES];
  logic [TAG_W-1:0]     tag_mem  [LINES];

  logic [TAG_W-1:0]     lk_tag;
  logic [IDX_W-1:0]     lk_set;
  logic [WORD_W-1:0]    lk_word;
  logic [IDX_W-1:0]     fidx_set;
  logic [3:0]           wmask;
  logic                 hit;
  logic [WAY_W-1:0]     hit_way;
  logic                 inv_found;
  logic [WAY_W-1:0]     inv_way;
  logic [WAY_W-1:0]     victim_next;
  logic [LI_W-1:0]      hit_idx;
  logic [LI_W-1:0]      vic_idx;
  logic [LI_W-1:0]      vnext_idx;
  logic [LINE_BITS-1:0] hit_line;

  assign lk_tag    = lk_addr[ADDR_W-1 -: TAG_W];
  assign lk_set    = lk_addr[OFF_W+IDX_W-1:OFF_W];
  assign lk_word   = lk_addr[OFF_W-1:2];
  assign fidx_set  = fidx[LI_W-1:WAY_W];
  assign hit_idx   = {lk_set, hit_way};
  assign vic_idx   = {lk_set, victim};
  assign vnext_idx = {lk_set, victim_next};
  assign hit_line  = data_mem[hit_idx];

  // Byte-lane write mask from access size and the low address bits.
  always_comb begin
    wmask = 4'b0000;
    case (Conf_dmem)
      4'd0, 4'd3, 4'd6: wmask = 4'b0001 << addr[1:0];
      4'd1, 4'd4, 4'd7: wmask = addr[1] ? 4'b1100 : 4'b0011;
      4'd2, 4'd5:       wmask = 4'b1111;
      default:          wmask = 4'b0000;
    endcase
  end

  // Tag compare over all ways; descending walk so the lowest index wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[{lk_set, WAY_W'(w)}] && tag_mem[{lk_set, WAY_W'(w)}] == lk_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid[{lk_set, WAY_W'(w)}]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim_next = inv_found ? inv_way : rr[lk_set];
  end

  // Control FSM plus valid/dirty/round-robin bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lk_addr  <= '0;
      lk_wdata <= '0;
      lk_wmask <= '0;
      lk_we    <= 1'b0;
      victim   <= '0;
      fidx     <= '0;
      valid    <= '0;
      dirty    <= '0;
      for (int s = 0; s < SETS; s++) rr[s] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            state <= FSCAN;
            fidx  <= '0;
          end else if (Wena || Rena) begin
            state    <= LOOKUP;
            lk_addr  <= addr[ADDR_W-1:2];
            lk_wdata <= Wdata;
            lk_wmask <= wmask;
            lk_we    <= Wena;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (lk_we) dirty[hit_idx] <= 1'b1;
            state <= IDLE;
          end else begin
            victim <= victim_next;
            state  <= (valid[vnext_idx] && dirty[vnext_idx]) ? WB : FILL;
          end
        end
        WB: if (mem.req_ready) state <= FILL;
        FILL: if (mem.req_ready) state <= WAIT;
        WAIT: begin
          if (mem.res_valid) begin
            valid[vic_idx] <= 1'b1;
            dirty[vic_idx] <= 1'b0;
            rr[lk_set]     <= rr[lk_set] + 1'b1;
            state          <= LOOKUP;
          end
        end
        FSCAN: begin
          if (valid[fidx] && dirty[fidx]) begin
            state <= FWB;
          end else begin
            valid[fidx] <= 1'b0;
            dirty[fidx] <= 1'b0;
            fidx        <= fidx + 1'b1;
            if (&fidx) state <= IDLE;
          end
        end
        FWB: begin
          if (mem.req_ready) begin
            valid[fidx] <= 1'b0;
            dirty[fidx] <= 1'b0;
            fidx        <= fidx + 1'b1;
            state       <= (&fidx) ? IDLE : FSCAN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line data and tags: store-hit byte merge and fill install.
  always_ff @(posedge clk) begin
    if (state == LOOKUP && hit && lk_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lk_wmask[b]) data_mem[hit_idx][{lk_word, 2'(b), 3'b000} +: 8] <= lk_wdata[b*8 +: 8];
      end
    end
    if (state == WAIT && mem.res_valid) begin
      data_mem[vic_idx] <= mem.res_Rdata;
      tag_mem[vic_idx]  <= lk_tag;
    end
  end

  // Pipeline-side outputs; Rdata only carries a word while Rdone is high.
  always_comb begin
    Rdone      = (state == LOOKUP) && hit && !lk_we;
    Wdone      = (state == LOOKUP) && hit && lk_we;
    Rdata      = Rdone ? hit_line[{lk_word, 5'b00000} +: 32] : 32'd0;
    flush_busy = (state == FSCAN) || (state == FWB);
    stall      = (state != IDLE && state != LOOKUP) ||
                 (state == IDLE && (Rena || Wena || flush));
  end

  // Memory bus; request fields derive from registered state so they hold while waiting.
  always_comb begin
    mem.req_valid = (state == WB) || (state == FILL) || (state == FWB);
    mem.write_en  = (state == WB) || (state == FWB);
    mem.res_ready = (state == WAIT);
    mem.req_addr  = '0;
    mem.req_Wdata = '0;
    case (state)
      WB: begin
        mem.req_addr  = {tag_mem[vic_idx], lk_set, {OFF_W{1'b0}}};
        mem.req_Wdata = data_mem[vic_idx];
      end
      FILL: mem.req_addr = {lk_tag, lk_set, {OFF_W{1'b0}}};
      FWB: begin
        mem.req_addr  = {tag_mem[fidx], fidx_set, {OFF_W{1'b0}}};
        mem.req_Wdata = data_mem[fidx];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_nway_wb.sv
// Directed self-checking bench for dcache_nway_wb (WAYS=4, SETS=64, LINE_BITS=128).
module tb_dcache_nway_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        flush_busy;
  logic [31:0] addr = '0;
  logic [3:0]  Conf_dmem = '0;
  logic [31:0] Wdata = '0;
  logic        Wena = 1'b0;
  logic        Rena = 1'b0;
  logic [31:0] Rdata;
  logic        Rdone;
  logic        Wdone;
  logic        stall;

  int total = 0;
  int bad = 0;

  logic [31:0]  exp_a [3];
  logic [127:0] exp_l [3];
  logic [31:0]  hold_addr;
  logic [127:0] hold_data;
  int cycles;
  int wbs;

  // 10-unit clock period
  always #5 clk = ~clk;

  dcache_nway_wb_if #(.ADDR_W(32), .LINE_BITS(128)) mem_if ();

  dcache_nway_wb #(.WAYS(4), .SETS(64), .LINE_BITS(128), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_busy(flush_busy),
    .addr(addr), .Conf_dmem(Conf_dmem), .Wdata(Wdata), .Wena(Wena), .Rena(Rena),
    .Rdata(Rdata), .Rdone(Rdone), .Wdone(Wdone), .stall(stall), .mem(mem_if)
  );

  // Fill pattern: word0..3 = 44/11/22/33 in the top byte, low bits echo the address
  function automatic logic [127:0] lf(input logic [31:0] a);
    return {8'h33, a[23:0], 8'h22, a[23:0], 8'h11, a[23:0], 8'h44, a[23:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [3:0] conf, input logic [31:0] wd);
    Rena = rd; Wena = wr; addr = a; Conf_dmem = conf; Wdata = wd;
    #1;
    checkOutput("accept_stall", stall, 1);
    tick();
    Rena = 1'b0; Wena = 1'b0;
    checkOutput("lookup_stall", stall, 0);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!mem_if.req_valid && n < 30) begin
      tick();
      n++;
    end
    if (!mem_if.req_valid) checkOutput("req_timeout", 0, 1);
  endtask

  task automatic serve_wb(input logic [31:0] a, input logic [127:0] line);
    wait_req();
    checkOutput("wb_we", mem_if.write_en, 1);
    checkOutput("wb_addr", mem_if.req_addr, a);
    checkOutput("wb_data", mem_if.req_Wdata, line);
    mem_if.req_ready = 1'b1;
    tick();
    mem_if.req_ready = 1'b0;
  endtask

  task automatic serve_fill(input logic [31:0] a, input logic [127:0] line);
    wait_req();
    checkOutput("fill_we", mem_if.write_en, 0);
    checkOutput("fill_addr", mem_if.req_addr, a);
    checkOutput("fill_stall", stall, 1);
    mem_if.req_ready = 1'b1;
    tick();
    mem_if.req_ready = 1'b0;
    checkOutput("res_ready", mem_if.res_ready, 1);
    mem_if.res_valid = 1'b1;
    mem_if.res_Rdata = line;
    tick();
    mem_if.res_valid = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic miss, input logic [127:0] line, input logic [31:0] word);
    applyStimulus(1'b1, 1'b0, a, 4'd2, 32'd0);
    if (miss) begin
      checkOutput("ld_miss_rdone", Rdone, 0);
      serve_fill({a[31:4], 4'h0}, line);
    end else begin
      checkOutput("ld_hit_noreq", mem_if.req_valid, 0);
    end
    checkOutput("rdone", Rdone, 1);
    checkOutput("rdata", Rdata, word);
    tick();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [3:0] conf, input logic [31:0] wd,
                          input logic miss, input logic [127:0] line);
    applyStimulus(1'b0, 1'b1, a, conf, wd);
    if (miss) begin
      checkOutput("st_miss_wdone", Wdone, 0);
      serve_fill({a[31:4], 4'h0}, line);
    end else begin
      checkOutput("st_hit_noreq", mem_if.req_valid, 0);
    end
    checkOutput("wdone", Wdone, 1);
    tick();
  endtask

  initial begin
    mem_if.req_ready = 1'b0;
    mem_if.res_valid = 1'b0;
    mem_if.res_Rdata = '0;

    // reset values
    tick(); tick();
    checkOutput("rst_rdone", Rdone, 0);
    checkOutput("rst_wdone", Wdone, 0);
    checkOutput("rst_req_valid", mem_if.req_valid, 0);
    checkOutput("rst_res_ready", mem_if.res_ready, 0);
    checkOutput("rst_flush_busy", flush_busy, 0);
    checkOutput("rst_write_en", mem_if.write_en, 0);
    checkOutput("rst_rdata", Rdata, 0);
    checkOutput("rst_stall", stall, 0);
    rst = 1'b1;
    tick();

    // cold load, hit reload, byte store merge
    do_load(32'h100, 1'b1, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_11223344, 32'h11223344);
    checkOutput("idle_rdone", Rdone, 0);
    do_load(32'h104, 1'b0, '0, 32'hBBBBBBBB);
    do_store(32'h101, 4'd0, 32'h0000AB00, 1'b0, '0);
    do_load(32'h100, 1'b0, '0, 32'h1122AB44);

    // fill set 0 with four lines, dirty way 0, then force an eviction
    do_load(32'h000, 1'b1, lf(32'h000), 32'h44000000);
    do_store(32'h000, 4'd2, 32'hCAFEF00D, 1'b0, '0);
    do_load(32'h400, 1'b1, lf(32'h400), 32'h44000400);
    do_load(32'h800, 1'b1, lf(32'h800), 32'h44000800);
    do_load(32'hC00, 1'b1, lf(32'hC00), 32'h44000C00);
    applyStimulus(1'b1, 1'b0, 32'h1000, 4'd2, 32'd0);
    checkOutput("evict_miss", Rdone, 0);
    wait_req();
    hold_addr = mem_if.req_addr;
    hold_data = mem_if.req_Wdata;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("hold_valid", mem_if.req_valid, 1);
      checkOutput("hold_addr", mem_if.req_addr, 32'h000);
      checkOutput("hold_data", mem_if.req_Wdata, 128'h33000000_22000000_11000000_CAFEF00D);
    end
    serve_wb(32'h000, 128'h33000000_22000000_11000000_CAFEF00D);
    serve_fill(32'h1000, lf(32'h1000));
    checkOutput("evict_rdone", Rdone, 1);
    checkOutput("evict_rdata", Rdata, 32'h44001000);
    tick();
    do_load(32'h400, 1'b0, '0, 32'h44000400);
    do_load(32'h000, 1'b1, lf(32'h000), 32'h44000000);

    // three dirty lines, then a full flush
    do_store(32'h804, 4'd2, 32'h5555AAAA, 1'b0, '0);
    do_store(32'h20A, 4'd1, 32'hBEEF0000, 1'b1, lf(32'h200));
    exp_a[0] = 32'h800; exp_l[0] = 128'h33000800_22000800_5555AAAA_44000800;
    exp_a[1] = 32'h100; exp_l[1] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_1122AB44;
    exp_a[2] = 32'h200; exp_l[2] = 128'h33000200_BEEF0200_11000200_44000200;
    flush = 1'b1;
    #1;
    checkOutput("flush_stall", stall, 1);
    tick();
    flush = 1'b0;
    checkOutput("flush_busy_on", flush_busy, 1);
    cycles = 0;
    wbs = 0;
    while (flush_busy && cycles < 1000) begin
      cycles++;
      if (mem_if.req_valid) begin
        checkOutput("fwb_we", mem_if.write_en, 1);
        if (wbs < 3) begin
          checkOutput("fwb_addr", mem_if.req_addr, exp_a[wbs]);
          checkOutput("fwb_data", mem_if.req_Wdata, exp_l[wbs]);
        end
        wbs++;
        mem_if.req_ready = 1'b1;
      end else begin
        mem_if.req_ready = 1'b0;
      end
      tick();
    end
    mem_if.req_ready = 1'b0;
    checkOutput("flush_wbs", wbs, 3);
    checkOutput("flush_cycles", cycles, 259);
    do_load(32'h104, 1'b1, lf(32'h100), 32'h11000100);
    do_load(32'h800, 1'b1, lf(32'h800), 32'h44000800);

    // reset while waiting for fill data
    applyStimulus(1'b1, 1'b0, 32'h300, 4'd2, 32'd0);
    wait_req();
    checkOutput("pre_rst_addr", mem_if.req_addr, 32'h300);
    mem_if.req_ready = 1'b1;
    tick();
    mem_if.req_ready = 1'b0;
    checkOutput("pre_rst_res_ready", mem_if.res_ready, 1);
    rst = 1'b0;
    mem_if.res_valid = 1'b1;
    mem_if.res_Rdata = lf(32'h300);
    tick();
    mem_if.res_valid = 1'b0;
    checkOutput("mid_rst_req_valid", mem_if.req_valid, 0);
    checkOutput("mid_rst_res_ready", mem_if.res_ready, 0);
    checkOutput("mid_rst_stall", stall, 0);
    checkOutput("mid_rst_rdone", Rdone, 0);
    rst = 1'b1;
    tick();
    do_load(32'h300, 1'b1, lf(32'h300), 32'h44000300);

    // simultaneous load and store behaves as a store
    applyStimulus(1'b1, 1'b1, 32'h300, 4'd2, 32'h12345678);
    checkOutput("both_wdone", Wdone, 1);
    checkOutput("both_rdone", Rdone, 0);
    tick();
    do_load(32'h300, 1'b0, '0, 32'h12345678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
